// File: rtl/pool_engine.sv
// Max-pool sequencer: reads 2-wide conv results from the pool-side buffer and
// writes one signed window maximum per output pixel into the conv-side buffer.
module pool_engine #(
  parameter int DATSIZE = 22
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           state_i,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 rd_en_o,
  output logic [5:0]           rd_y_o,
  output logic [5:0]           rd_x_o,
  output logic [5:0]           rd_c_o,
  output logic                 rd_updown_o,
  input  logic [2*DATSIZE-1:0] rd_data_i,
  output logic                 wr_en_o,
  output logic [4:0]           wr_y_o,
  output logic [4:0]           wr_x_o,
  output logic [5:0]           wr_c_o,
  output logic [DATSIZE-1:0]   wr_data_o
);

  localparam logic [3:0] POOL1 = 4'b0011;
  localparam logic [3:0] POOL2 = 4'b0101;
  localparam logic [3:0] POOL3 = 4'b0111;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} fsm_t;

  fsm_t       fsm_q, fsm_d;
  logic [3:0] mode_q;
  logic [2:0] k_q;
  logic [4:0] ox_q, oy_q;
  logic [5:0] c_q;
  logic       drain_q;

  // Window geometry of the mode latched at start
  logic [4:0] x_max, y_max;
  logic [5:0] c_max;
  logic [2:0] k_max;
  logic       wide_win;

  always_comb begin
    x_max    = 5'd15;
    y_max    = 5'd15;
    c_max    = 6'd15;
    k_max    = 3'd1;
    wide_win = 1'b0;
    case (mode_q)
      POOL2: begin
        x_max = 5'd7;
        y_max = 5'd7;
        c_max = 6'd31;
      end
      POOL3: begin
        x_max    = 5'd1;
        y_max    = 5'd1;
        c_max    = 6'd63;
        k_max    = 3'd7;
        wide_win = 1'b1;
      end
      default: ;
    endcase
  end

  logic is_pool, busy, abort, start_ok, rd_en;
  logic last_k, last_x, last_y, last_c, last_read;

  assign is_pool   = (state_i == POOL1) || (state_i == POOL2) || (state_i == POOL3);
  assign busy      = (fsm_q == RUN) || (fsm_q == DRAIN);
  assign abort     = busy && (state_i != mode_q);
  assign last_k    = (k_q == k_max);
  assign last_x    = (ox_q == x_max);
  assign last_y    = (oy_q == y_max);
  assign last_c    = (c_q == c_max);
  assign last_read = last_k && last_x && last_y && last_c;

  always_comb begin
    fsm_d    = fsm_q;
    start_ok = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (start_i && is_pool) begin
          fsm_d    = RUN;
          start_ok = 1'b1;
        end
      end
      RUN: begin
        if (abort) fsm_d = IDLE;
        else if (last_read) fsm_d = DRAIN;
      end
      DRAIN: begin
        if (abort) fsm_d = IDLE;
        else if (drain_q) fsm_d = FIN;
      end
      FIN:     fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q   <= IDLE;
      drain_q <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      drain_q <= (fsm_q == DRAIN) && !drain_q && !abort;
    end
  end

  assign rd_en   = (fsm_q == RUN) && !abort;
  assign busy_o  = busy;
  assign done_o  = (fsm_q == FIN);
  assign rd_en_o = rd_en;

  // Scan counters: k fastest, then x, then y, channel outermost
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= 4'd0;
      k_q    <= 3'd0;
      ox_q   <= 5'd0;
      oy_q   <= 5'd0;
      c_q    <= 6'd0;
    end else if (start_ok || abort) begin
      k_q  <= 3'd0;
      ox_q <= 5'd0;
      oy_q <= 5'd0;
      c_q  <= 6'd0;
      if (start_ok) mode_q <= state_i;
    end else if (rd_en) begin
      if (!last_k) begin
        k_q <= k_q + 3'd1;
      end else begin
        k_q <= 3'd0;
        if (!last_x) begin
          ox_q <= ox_q + 5'd1;
        end else begin
          ox_q <= 5'd0;
          if (!last_y) begin
            oy_q <= oy_q + 5'd1;
          end else begin
            oy_q <= 5'd0;
            c_q  <= last_c ? 6'd0 : c_q + 6'd1;
          end
        end
      end
    end
  end

  // 4x4 windows split k into {dy, updown, dx}; 2x2 windows only toggle updown
  always_comb begin
    rd_y_o      = 6'd0;
    rd_x_o      = 6'd0;
    rd_c_o      = 6'd0;
    rd_updown_o = 1'b0;
    if (rd_en) begin
      rd_c_o = c_q;
      if (wide_win) begin
        rd_y_o      = {oy_q, k_q[2]};
        rd_x_o      = {ox_q, k_q[0]};
        rd_updown_o = k_q[1];
      end else begin
        rd_y_o      = {1'b0, oy_q};
        rd_x_o      = {1'b0, ox_q};
        rd_updown_o = k_q[0];
      end
    end
  end

  // Beat tags follow each read by one cycle so they line up with rd_data_i
  logic       beat_v_q, beat_first_q, beat_last_q;
  logic [5:0] beat_c_q;
  logic [4:0] beat_y_q, beat_x_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_v_q     <= 1'b0;
      beat_first_q <= 1'b0;
      beat_last_q  <= 1'b0;
      beat_c_q     <= 6'd0;
      beat_y_q     <= 5'd0;
      beat_x_q     <= 5'd0;
    end else if (abort) begin
      beat_v_q     <= 1'b0;
      beat_first_q <= 1'b0;
      beat_last_q  <= 1'b0;
    end else begin
      beat_v_q     <= rd_en;
      beat_first_q <= (k_q == 3'd0);
      beat_last_q  <= last_k;
      beat_c_q     <= c_q;
      beat_y_q     <= oy_q;
      beat_x_q     <= ox_q;
    end
  end

  logic signed [DATSIZE-1:0] lo, hi, pair_max, win_max, acc_q, wr_data_q;
  logic                      wr_en_q, wr_beat;
  logic [5:0]                wr_c_q;
  logic [4:0]                wr_y_q, wr_x_q;

  // Ties keep the earlier operand (even element, then running accumulator)
  assign lo       = rd_data_i[DATSIZE-1:0];
  assign hi       = rd_data_i[2*DATSIZE-1:DATSIZE];
  assign pair_max = (hi > lo) ? hi : lo;
  assign win_max  = (pair_max > acc_q) ? pair_max : acc_q;
  assign wr_beat  = beat_v_q && beat_last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      wr_c_q    <= 6'd0;
      wr_y_q    <= 5'd0;
      wr_x_q    <= 5'd0;
    end else if (abort) begin
      acc_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      wr_c_q    <= 6'd0;
      wr_y_q    <= 5'd0;
      wr_x_q    <= 5'd0;
    end else begin
      if (beat_v_q) acc_q <= beat_first_q ? pair_max : win_max;
      wr_en_q   <= wr_beat;
      wr_data_q <= wr_beat ? win_max : '0;
      wr_c_q    <= wr_beat ? beat_c_q : 6'd0;
      wr_y_q    <= wr_beat ? beat_y_q : 5'd0;
      wr_x_q    <= wr_beat ? beat_x_q : 5'd0;
    end
  end

  assign wr_en_o   = wr_en_q;
  assign wr_data_o = wr_data_q;
  assign wr_c_o    = wr_c_q;
  assign wr_y_o    = wr_y_q;
  assign wr_x_o    = wr_x_q;

endmodule

// File: tb/tb_pool_engine.sv
// Bench for pool_engine: hashed random feature maps served by a 1-cycle read
// model, window maxima recomputed from input-image coordinates.
module tb_pool_engine;
  localparam int D = 22;
  localparam logic [3:0] P1 = 4'b0011;
  localparam logic [3:0] P2 = 4'b0101;
  localparam logic [3:0] P3 = 4'b0111;

  logic           clk = 1'b0;
  logic           rst;
  logic [3:0]     state_i;
  logic           start_i;
  logic           busy_o, done_o, rd_en_o, rd_updown_o, wr_en_o;
  logic [5:0]     rd_y_o, rd_x_o, rd_c_o, wr_c_o;
  logic [2*D-1:0] rd_data_i;
  logic [4:0]     wr_y_o, wr_x_o;
  logic [D-1:0]   wr_data_o;
  logic [60:0]    all_out;

  always #5 clk = ~clk;

  pool_engine #(.DATSIZE(D)) dut (
    .clk(clk), .rst(rst), .state_i(state_i), .start_i(start_i),
    .busy_o(busy_o), .done_o(done_o), .rd_en_o(rd_en_o),
    .rd_y_o(rd_y_o), .rd_x_o(rd_x_o), .rd_c_o(rd_c_o), .rd_updown_o(rd_updown_o),
    .rd_data_i(rd_data_i), .wr_en_o(wr_en_o), .wr_y_o(wr_y_o), .wr_x_o(wr_x_o),
    .wr_c_o(wr_c_o), .wr_data_o(wr_data_o)
  );

  assign all_out = {busy_o, done_o, rd_en_o, rd_y_o, rd_x_o, rd_c_o, rd_updown_o,
                    wr_en_o, wr_y_o, wr_x_o, wr_c_o, wr_data_o};

  typedef struct {int c; int y; int x; int d; int t;} wr_rec_t;
  typedef struct {int c; int y; int x; int ud; int t;} rd_rec_t;

  wr_rec_t     wr_q[$];
  rd_rec_t     rd_q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          t0 = 0;
  logic [31:0] seed;
  bit          zero_fill;
  int          ovr[int];

  // Input image element at (channel, input row, input column)
  function automatic int elem(int c, int r, int col);
    int key = c * 65536 + r * 256 + col;
    logic [31:0] h;
    logic signed [21:0] v;
    if (ovr.exists(key)) return ovr[key];
    if (zero_fill) return 0;
    h = seed ^ (32'(c) * 32'h9E3779B1) ^ (32'(r) * 32'h85EBCA77) ^ (32'(col) * 32'hC2B2AE3D);
    h = h ^ (h >> 15);
    h = h * 32'h2C1B3C6D;
    h = h ^ (h >> 13);
    v = h[21:0];
    return int'(v);
  endfunction

  function automatic void set_elem(int c, int r, int col, int v);
    ovr[c * 65536 + r * 256 + col] = v;
  endfunction

  function automatic void geom(input logic [3:0] mode, output int h, output int w,
                               output int ch, output int k);
    if (mode == P1) begin h = 16; w = 16; ch = 16; k = 2; end
    else if (mode == P2) begin h = 8; w = 8; ch = 32; k = 2; end
    else begin h = 2; w = 2; ch = 64; k = 8; end
  endfunction

  function automatic int exp_max(logic [3:0] mode, int c, int oy, int ox);
    int win = (mode == P3) ? 4 : 2;
    int best = elem(c, win * oy, win * ox);
    for (int r = 0; r < win; r++)
      for (int q = 0; q < win; q++)
        if (elem(c, win * oy + r, win * ox + q) > best) best = elem(c, win * oy + r, win * ox + q);
    return best;
  endfunction

  // Pool buffer: word = {odd column, even column} of input row 2*rd_y+updown
  always @(posedge clk) begin
    if (rd_en_o)
      rd_data_i <= {22'(elem(int'(rd_c_o), 2 * int'(rd_y_o) + int'(rd_updown_o), 2 * int'(rd_x_o) + 1)),
                    22'(elem(int'(rd_c_o), 2 * int'(rd_y_o) + int'(rd_updown_o), 2 * int'(rd_x_o)))};
    else
      rd_data_i <= 44'({$urandom(), $urandom()});
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en_o)
      wr_q.push_back('{int'(wr_c_o), int'(wr_y_o), int'(wr_x_o), int'(signed'(wr_data_o)), cyc - t0});
    if (rd_en_o)
      rd_q.push_back('{int'(rd_c_o), int'(rd_y_o), int'(rd_x_o), int'(rd_updown_o), cyc - t0});
  end

  // Start cycle is cycle 0; returns the cycle index where done is seen, or -1
  task automatic run(input logic [3:0] mode, input int restart_at, output int done_cyc);
    int rel;
    done_cyc = -1;
    @(negedge clk);
    wr_q.delete();
    rd_q.delete();
    state_i = mode;
    start_i = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start_i = 1'b0;
    rel = cyc - t0;
    while (rel <= 9000) begin
      if (done_o) begin
        done_cyc = rel;
        break;
      end
      start_i = (rel == restart_at);
      @(negedge clk);
      rel = cyc - t0;
    end
    start_i = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    state_i = 4'd0;
    start_i = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (all_out !== 61'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", all_out);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (all_out !== 61'd0) begin
      failures++;
      $display("FAIL idle_outputs got=%h exp=0", all_out);
    end
  endtask

  task automatic test_pool1;
    int dc, h, w, ch, k;
    seed = $urandom();
    zero_fill = 0;
    ovr.delete();
    set_elem(0, 0, 1, 5);  set_elem(0, 0, 0, -3);
    set_elem(0, 1, 1, 7);  set_elem(0, 1, 0, 2);
    geom(P1, h, w, ch, k);
    run(P1, -1, dc);
    checks++;
    if (dc !== 8195) begin failures++; $display("FAIL pool1_done_cycle got=%0d exp=8195", dc); end
    checks++;
    if (busy_o !== 1'b0) begin failures++; $display("FAIL pool1_busy_at_done got=%b exp=0", busy_o); end
    checks++;
    if (wr_q.size() !== 4096) begin failures++; $display("FAIL pool1_write_count got=%0d exp=4096", wr_q.size()); end
    checks++;
    if (wr_q.size() == 0 || wr_q[0].d !== 7 || wr_q[0].t !== 4)
      begin failures++; $display("FAIL pool1_first_write got=(d=%0d t=%0d) exp=(d=7 t=4)",
                                 wr_q.size() ? wr_q[0].d : -1, wr_q.size() ? wr_q[0].t : -1); end
    for (int i = 0; i < wr_q.size(); i++) begin
      int c = i / (h * w);
      int oy = (i / w) % h;
      int ox = i % w;
      int e = exp_max(P1, c, oy, ox);
      int et = (i + 1) * k + 2;
      checks++;
      if (wr_q[i].c !== c || wr_q[i].y !== oy || wr_q[i].x !== ox || wr_q[i].d !== e || wr_q[i].t !== et) begin
        failures++;
        $display("FAIL pool1_write[%0d] got=(c%0d y%0d x%0d d%0d t%0d) exp=(c%0d y%0d x%0d d%0d t%0d)",
                 i, wr_q[i].c, wr_q[i].y, wr_q[i].x, wr_q[i].d, wr_q[i].t, c, oy, ox, e, et);
      end
    end
    @(negedge clk);
    checks++;
    if (done_o !== 1'b0) begin failures++; $display("FAIL pool1_done_width got=%b exp=0", done_o); end
  endtask

  task automatic test_pool2_negative;
    int dc, h, w, ch, k, nc, ny, nx, ni;
    seed = $urandom();
    zero_fill = 0;
    ovr.delete();
    nc = $urandom_range(0, 31);
    ny = $urandom_range(0, 7);
    nx = $urandom_range(0, 7);
    set_elem(nc, 2 * ny, 2 * nx + 1, -10);     set_elem(nc, 2 * ny, 2 * nx, -4);
    set_elem(nc, 2 * ny + 1, 2 * nx + 1, -9);  set_elem(nc, 2 * ny + 1, 2 * nx, -20);
    geom(P2, h, w, ch, k);
    run(P2, -1, dc);
    checks++;
    if (dc !== 4099) begin failures++; $display("FAIL pool2_done_cycle got=%0d exp=4099", dc); end
    checks++;
    if (wr_q.size() !== 2048) begin failures++; $display("FAIL pool2_write_count got=%0d exp=2048", wr_q.size()); end
    ni = nc * 64 + ny * 8 + nx;
    checks++;
    if (ni >= wr_q.size() || wr_q[ni].d !== -4)
      begin failures++; $display("FAIL pool2_negative_window got=%0d exp=-4", ni < wr_q.size() ? wr_q[ni].d : 0); end
    for (int i = 0; i < wr_q.size(); i++) begin
      int c = i / (h * w);
      int oy = (i / w) % h;
      int ox = i % w;
      int e = exp_max(P2, c, oy, ox);
      int et = (i + 1) * k + 2;
      checks++;
      if (wr_q[i].c !== c || wr_q[i].y !== oy || wr_q[i].x !== ox || wr_q[i].d !== e || wr_q[i].t !== et) begin
        failures++;
        $display("FAIL pool2_write[%0d] got=(c%0d y%0d x%0d d%0d t%0d) exp=(c%0d y%0d x%0d d%0d t%0d)",
                 i, wr_q[i].c, wr_q[i].y, wr_q[i].x, wr_q[i].d, wr_q[i].t, c, oy, ox, e, et);
      end
    end
  endtask

  task automatic test_pool3;
    int dc;
    zero_fill = 1;
    ovr.delete();
    set_elem(5, 6, 1, 100);
    run(P3, -1, dc);
    checks++;
    if (dc !== 2051) begin failures++; $display("FAIL pool3_done_cycle got=%0d exp=2051", dc); end
    checks++;
    if (wr_q.size() !== 256) begin failures++; $display("FAIL pool3_write_count got=%0d exp=256", wr_q.size()); end
    for (int i = 0; i < wr_q.size(); i++) begin
      int c = i / 4;
      int oy = (i / 2) % 2;
      int ox = i % 2;
      int e = (c == 5 && oy == 1 && ox == 0) ? 100 : 0;
      checks++;
      if (wr_q[i].c !== c || wr_q[i].y !== oy || wr_q[i].x !== ox || wr_q[i].d !== e || wr_q[i].t !== (i + 1) * 8 + 2) begin
        failures++;
        $display("FAIL pool3_write[%0d] got=(c%0d y%0d x%0d d%0d t%0d) exp=(c%0d y%0d x%0d d%0d t%0d)",
                 i, wr_q[i].c, wr_q[i].y, wr_q[i].x, wr_q[i].d, wr_q[i].t, c, oy, ox, e, (i + 1) * 8 + 2);
      end
    end
    checks++;
    if (rd_q.size() !== 2048) begin failures++; $display("FAIL pool3_read_count got=%0d exp=2048", rd_q.size()); end
    for (int i = 0; i < rd_q.size(); i++) begin
      int c = i / 32;
      int oy = (i / 16) % 2;
      int ox = (i / 8) % 2;
      int kk = i % 8;
      int ey = 2 * oy + kk / 4;
      int eud = (kk / 2) % 2;
      int ex = 2 * ox + kk % 2;
      checks++;
      if (rd_q[i].c !== c || rd_q[i].y !== ey || rd_q[i].ud !== eud || rd_q[i].x !== ex || rd_q[i].t !== i + 1) begin
        failures++;
        $display("FAIL pool3_read[%0d] got=(c%0d y%0d ud%0d x%0d t%0d) exp=(c%0d y%0d ud%0d x%0d t%0d)",
                 i, rd_q[i].c, rd_q[i].y, rd_q[i].ud, rd_q[i].x, rd_q[i].t, c, ey, eud, ex, i + 1);
      end
    end
  endtask

  task automatic test_ignore_start;
    @(negedge clk);
    state_i = 4'b0010;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (all_out !== 61'd0) begin failures++; $display("FAIL ignore_start[%0d] got=%h exp=0", i, all_out); end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    int dc;
    zero_fill = 0;
    ovr.delete();
    seed = $urandom();
    run(P3, -1, dc);
    checks++;
    if (dc !== 2051) begin failures++; $display("FAIL b2b_first_done got=%0d exp=2051", dc); end
    seed = $urandom();
    run(P3, 100, dc);
    checks++;
    if (dc !== 2051) begin failures++; $display("FAIL b2b_restart_done got=%0d exp=2051", dc); end
    checks++;
    if (wr_q.size() !== 256) begin failures++; $display("FAIL b2b_write_count got=%0d exp=256", wr_q.size()); end
    for (int i = 0; i < wr_q.size(); i++) begin
      int c = i / 4;
      int oy = (i / 2) % 2;
      int ox = i % 2;
      int e = exp_max(P3, c, oy, ox);
      checks++;
      if (wr_q[i].c !== c || wr_q[i].y !== oy || wr_q[i].x !== ox || wr_q[i].d !== e) begin
        failures++;
        $display("FAIL b2b_write[%0d] got=(c%0d y%0d x%0d d%0d) exp=(c%0d y%0d x%0d d%0d)",
                 i, wr_q[i].c, wr_q[i].y, wr_q[i].x, wr_q[i].d, c, oy, ox, e);
      end
    end
  endtask

  task automatic test_abort_state;
    int dc;
    seed = $urandom();
    zero_fill = 0;
    ovr.delete();
    @(negedge clk);
    wr_q.delete();
    state_i = P1;
    start_i = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start_i = 1'b0;
    while (cyc - t0 < 100) @(negedge clk);
    state_i = 4'b0110;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      checks++;
      if (all_out !== 61'd0) begin failures++; $display("FAIL abort_state_idle[%0d] got=%h exp=0", i, all_out); end
    end
    // writes land at cycles 4,6,..,100 before the abort takes effect
    checks++;
    if (wr_q.size() !== 49) begin failures++; $display("FAIL abort_state_writes got=%0d exp=49", wr_q.size()); end
    run(P3, -1, dc);
    checks++;
    if (dc !== 2051 || wr_q.size() !== 256 || wr_q[255].d !== exp_max(P3, 63, 1, 1))
      begin failures++; $display("FAIL abort_state_restart got=(done %0d writes %0d) exp=(done 2051 writes 256)", dc, wr_q.size()); end
  endtask

  task automatic test_abort_reset;
    int dc;
    seed = $urandom();
    @(negedge clk);
    state_i = P2;
    start_i = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start_i = 1'b0;
    while (cyc - t0 < 50) @(negedge clk);
    checks++;
    if (busy_o !== 1'b1) begin failures++; $display("FAIL abort_reset_busy got=%b exp=1", busy_o); end
    rst = 1'b1;
    #1;
    checks++;
    if (all_out !== 61'd0) begin failures++; $display("FAIL abort_reset_async got=%h exp=0", all_out); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (all_out !== 61'd0) begin failures++; $display("FAIL abort_reset_idle[%0d] got=%h exp=0", i, all_out); end
    end
    run(P3, -1, dc);
    checks++;
    if (dc !== 2051 || wr_q.size() !== 256 || wr_q[0].d !== exp_max(P3, 0, 0, 0))
      begin failures++; $display("FAIL abort_reset_restart got=(done %0d writes %0d) exp=(done 2051 writes 256)", dc, wr_q.size()); end
  endtask

  initial begin
    test_reset();
    test_pool1();
    test_pool2_negative();
    test_pool3();
    test_ignore_start();
    test_back_to_back();
    test_abort_state();
    test_abort_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
